block_zigzag_rle: RTL

Consumes one quantized 8×8 coefficient block from the DCT/quantizer stage and emits its H.261-style token stream: an optional intra DC token, (run, level) tokens in zigzag order, and an end-of-block token. It sits directly downstream of the transform stage and upstream of the variable-length coder. Output uses a valid/ready handshake so the VLC can stall it.

---
 rtl/block_zigzag_rle_if.sv | 25 ++
 rtl/block_zigzag_rle.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/block_zigzag_rle_if.sv
// Token output bus of block_zigzag_rle: a valid/ready channel carrying
// (kind, run, level) tokens toward the variable-length coder.
interface block_zigzag_rle_if;
    logic              tok_valid;
    logic              tok_ready;
    logic [1:0]        tok_kind;
    logic [5:0]        tok_run;
    logic signed [7:0] tok_level;

    modport master (
        output tok_valid,
        output tok_kind,
        output tok_run,
        output tok_level,
        input  tok_ready
    );

    modport slave (
        input  tok_valid,
        input  tok_kind,
        input  tok_run,
        input  tok_level,
        output tok_ready
    );
endinterface

// File: rtl/block_zigzag_rle.sv
// block_zigzag_rle: captures one quantized 8x8 block, walks it in zigzag
// order and emits DC / (run, level) AC / EOB tokens on a valid/ready bus.
// Build macro: ZIGZAG_RLE_SKIP_EMPTY_EN -- when defined, an all-zero inter
// block produces no tokens and only a block_done pulse.
//
// state  | meaning
// -------+--------------------------------------------------------------
// S_IDLE | waiting for block_valid; output register empty
// S_SCAN | one zigzag coefficient per free output slot, k = scan index
// S_EOB  | scan finished; issue EOB (or skip it) and wait for acceptance
module block_zigzag_rle (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        block_valid,
    input  logic signed [7:0][7:0][7:0] data_in,
    input  logic                        is_intra,
    block_zigzag_rle_if.master          tok,
    output logic                        busy,
    output logic                        block_done,
    output logic                        overrun
);
    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_EOB} state_t;

    localparam logic [1:0] KIND_DC  = 2'd0;
    localparam logic [1:0] KIND_AC  = 2'd1;
    localparam logic [1:0] KIND_EOB = 2'd2;

    // Zigzag position k -> raster index u*8+v into the captured block.
    localparam logic [5:0] ZZ_ROM [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    state_t            state_q, state_d;
    logic [5:0]        k_q, k_d;
    logic [5:0]        run_q, run_d;
    logic              intra_q, intra_d;
    logic              any_ac_q, any_ac_d;
    logic              tok_valid_q, tok_valid_d;
    logic [1:0]        tok_kind_q, tok_kind_d;
    logic [5:0]        tok_run_q, tok_run_d;
    logic signed [7:0] tok_level_q, tok_level_d;
    // Same packed layout as data_in: entry u*8+v holds coefficient [u][v].
    logic [63:0][7:0]  coef_q, coef_d;

    logic [7:0]        coef_cur;
    logic              out_free;
    logic              skip_empty;

    // An inter block that produced no AC token is the "uncoded" case.
`ifdef ZIGZAG_RLE_SKIP_EMPTY_EN
    assign skip_empty = !intra_q && !any_ac_q;
`else
    assign skip_empty = 1'b0;
`endif

    assign coef_cur = coef_q[ZZ_ROM[k_q]];
    assign out_free = !tok_valid_q || tok.tok_ready;

    // Next-state, scan datapath and token register load.
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        run_d       = run_q;
        intra_d     = intra_q;
        any_ac_d    = any_ac_q;
        coef_d      = coef_q;
        tok_valid_d = tok_valid_q;
        tok_kind_d  = tok_kind_q;
        tok_run_d   = tok_run_q;
        tok_level_d = tok_level_q;
        block_done  = 1'b0;

        if (tok_valid_q && tok.tok_ready) begin
            tok_valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (block_valid) begin
                    coef_d   = data_in;
                    intra_d  = is_intra;
                    any_ac_d = 1'b0;
                    run_d    = 6'd0;
                    k_d      = is_intra ? 6'd1 : 6'd0;
                    state_d  = S_SCAN;
                    if (is_intra) begin
                        tok_valid_d = 1'b1;
                        tok_kind_d  = KIND_DC;
                        tok_run_d   = 6'd0;
                        tok_level_d = data_in[0][0];
                    end
                end
            end
            S_SCAN: begin
                if (out_free) begin
                    if (coef_cur != 8'd0) begin
                        tok_valid_d = 1'b1;
                        tok_kind_d  = KIND_AC;
                        tok_run_d   = run_q;
                        tok_level_d = coef_cur;
                        run_d       = 6'd0;
                        any_ac_d    = 1'b1;
                    end else begin
                        run_d = run_q + 6'd1;
                    end
                    if (k_q == 6'd63) begin
                        k_d     = 6'd0;
                        state_d = S_EOB;
                        // Trailing zero: the slot is free now, so EOB goes out
                        // on the very next cycle instead of one later.
                        if (coef_cur == 8'd0 && !skip_empty) begin
                            tok_valid_d = 1'b1;
                            tok_kind_d  = KIND_EOB;
                            tok_run_d   = 6'd0;
                            tok_level_d = 8'sd0;
                        end
                    end else begin
                        k_d = k_q + 6'd1;
                    end
                end
            end
            S_EOB: begin
                if (tok_valid_q && tok_kind_q == KIND_EOB) begin
                    if (tok.tok_ready) begin
                        block_done = 1'b1;
                        state_d    = S_IDLE;
                    end
                end else if (skip_empty) begin
                    block_done = 1'b1;
                    state_d    = S_IDLE;
                end else if (out_free) begin
                    tok_valid_d = 1'b1;
                    tok_kind_d  = KIND_EOB;
                    tok_run_d   = 6'd0;
                    tok_level_d = 8'sd0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control and token registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            k_q         <= 6'd0;
            run_q       <= 6'd0;
            intra_q     <= 1'b0;
            any_ac_q    <= 1'b0;
            tok_valid_q <= 1'b0;
            tok_kind_q  <= 2'd0;
            tok_run_q   <= 6'd0;
            tok_level_q <= 8'sd0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            run_q       <= run_d;
            intra_q     <= intra_d;
            any_ac_q    <= any_ac_d;
            tok_valid_q <= tok_valid_d;
            tok_kind_q  <= tok_kind_d;
            tok_run_q   <= tok_run_d;
            tok_level_q <= tok_level_d;
        end
    end

    // Coefficient buffer; contents only matter after a capture.
    always_ff @(posedge clk) begin
        coef_q <= coef_d;
    end

    assign tok.tok_valid = tok_valid_q;
    assign tok.tok_kind  = tok_kind_q;
    assign tok.tok_run   = tok_run_q;
    assign tok.tok_level = tok_level_q;
    assign busy          = (state_q != S_IDLE);
    assign overrun       = block_valid && (state_q != S_IDLE);
endmodule
